// File: rtl/core_decode_stage.sv
// -----------------------------------------------------------------------------
// core_decode_stage
//   Registered RV32/RV64 instruction decode stage between fetch and execute.
//   Instruction words arrive over a valid/ready handshake, are decoded
//   combinationally at the input transfer and the result is registered.
//   A two-entry store (output register + skid register) keeps backpressure
//   from execute off any combinational path back to fetch: o_ready is a
//   flop that simply reflects "skid register empty".
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_flush            drop every buffered entry (and this cycle's input)
//   i_valid/o_ready    fetch-side handshake; i_instr, i_pc are the payload
//   o_valid/i_ready    execute-side handshake
//   o_pc               PC travelling with the decoded entry
//   o_opcode           instr[6:2]
//   o_format           R=0 I=1 S=2 B=3 U=4 J=5 UIMM=6
//   o_imm              immediate, sign-extended to XLEN (UIMM zero-extended)
//   o_rd/o_rs1/o_rs2   register indices
//   o_funct3/o_funct7  raw function fields
//   o_illegal          entry is an illegal instruction (still flows through)
// -----------------------------------------------------------------------------
module core_decode_stage #(
  parameter int XLEN         = 32,
  parameter int ENABLE_M     = 1,
  parameter int ENABLE_A     = 0,
  parameter int ENABLE_ZICSR = 1,
  parameter int PC_WIDTH     = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [4:0]          o_opcode,
  output logic [2:0]          o_format,
  output logic [XLEN-1:0]     o_imm,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [2:0]          o_funct3,
  output logic [6:0]          o_funct7,
  output logic                o_illegal
);

  typedef enum logic [4:0] {
    OPC_LOAD      = 5'b00000,
    OPC_MISC_MEM  = 5'b00011,
    OPC_OP_IMM    = 5'b00100,
    OPC_AUIPC     = 5'b00101,
    OPC_OP_IMM_32 = 5'b00110,
    OPC_STORE     = 5'b01000,
    OPC_AMO       = 5'b01011,
    OPC_OP        = 5'b01100,
    OPC_LUI       = 5'b01101,
    OPC_OP_32     = 5'b01110,
    OPC_BRANCH    = 5'b11000,
    OPC_JALR      = 5'b11001,
    OPC_JAL       = 5'b11011,
    OPC_SYSTEM    = 5'b11100
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_UIMM = 3'd6
  } format_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          opcode;
    logic [2:0]          fmt;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  entry_t     dec;
  format_e    fmt;
  logic       known;
  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    opc   = i_instr[6:2];
    f3    = i_instr[14:12];
    f7    = i_instr[31:25];
    known = 1'b1;
    fmt   = FMT_R;

    case (opc)
      OPC_OP, OPC_OP_32, OPC_AMO:                               fmt = FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_MISC_MEM: fmt = FMT_I;
      OPC_STORE:                                                fmt = FMT_S;
      OPC_BRANCH:                                               fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                                       fmt = FMT_U;
      OPC_JAL:                                                  fmt = FMT_J;
      // CSR immediate forms carry a 5-bit zero-extended uimm in the rs1 slot
      OPC_SYSTEM:                                               fmt = f3[2] ? FMT_UIMM : FMT_I;
      default: begin
        fmt   = FMT_R;
        known = 1'b0;
      end
    endcase

    dec        = '0;
    dec.pc     = i_pc;
    dec.opcode = opc;
    dec.fmt    = fmt;
    dec.rd     = i_instr[11:7];
    dec.rs1    = i_instr[19:15];
    dec.rs2    = i_instr[24:20];
    dec.funct3 = f3;
    dec.funct7 = f7;

    case (fmt)
      FMT_I:    dec.imm = XLEN'($signed(i_instr[31:20]));
      FMT_S:    dec.imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      FMT_B:    dec.imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                         i_instr[11:8], 1'b0}));
      FMT_U:    dec.imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      FMT_J:    dec.imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                         i_instr[30:21], 1'b0}));
      FMT_UIMM: dec.imm = XLEN'(i_instr[19:15]);
      default:  dec.imm = '0;
    endcase

    // All-zero and all-one words are typical of unprogrammed memory
    dec.illegal = (i_instr[1:0] != 2'b11) || !known ||
                  (i_instr == 32'h0000_0000) || (i_instr == 32'hFFFF_FFFF);
    if ((opc == OPC_AMO) && (ENABLE_A == 0))
      dec.illegal = 1'b1;
    if (((opc == OPC_OP_IMM_32) || (opc == OPC_OP_32)) && (XLEN == 32))
      dec.illegal = 1'b1;
    if (((opc == OPC_OP) || (opc == OPC_OP_32)) &&
        !((f7 == 7'b0000000) || (f7 == 7'b0100000) ||
          ((ENABLE_M != 0) && (f7 == 7'b0000001))))
      dec.illegal = 1'b1;
    if ((opc == OPC_SYSTEM) && (f3 != 3'b000) && (ENABLE_ZICSR == 0))
      dec.illegal = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output register (or) + skid register (sk)
  // ---------------------------------------------------------------------------
  entry_t or_q, or_d, sk_q, sk_d;
  logic   or_valid_q, or_valid_d;
  logic   sk_valid_q, sk_valid_d;
  logic   ready_q, ready_d;
  logic   in_xfer, out_xfer;

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = or_valid_q && i_ready;

  always_comb begin
    or_d       = or_q;
    sk_d       = sk_q;
    or_valid_d = or_valid_q;
    sk_valid_d = sk_valid_q;

    if (i_flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || out_xfer) begin
      // Output slot frees up this edge. ready_q is low whenever the skid is
      // full, so a skid refill and a new input never compete for it.
      if (sk_valid_q) begin
        or_d       = sk_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
      end else if (in_xfer) begin
        or_d       = dec;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      sk_d       = dec;
      sk_valid_d = 1'b1;
    end

    ready_d = !sk_valid_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
      ready_q    <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = or_valid_q;
  assign o_pc      = or_q.pc;
  assign o_opcode  = or_q.opcode;
  assign o_format  = or_q.fmt;
  assign o_imm     = or_q.imm;
  assign o_rd      = or_q.rd;
  assign o_rs1     = or_q.rs1;
  assign o_rs2     = or_q.rs2;
  assign o_funct3  = or_q.funct3;
  assign o_funct7  = or_q.funct7;
  assign o_illegal = or_q.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage. Two instances share all stimulus:
//   dut a: XLEN=32, M=1, A=0, ZICSR=1
//   dut b: XLEN=64, M=0, A=1, ZICSR=0
// Occupancy is modelled as a queue of accepted {pc, word} pairs; decoded
// fields are derived from the word with plain arithmetic.
module tb_core_decode_stage;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_UIMM = 3'd6;

  logic clk, rst, flush, valid, rdy;
  logic [31:0] instr, pc;

  logic        o_ready_a, o_valid_a, o_illegal_a;
  logic [31:0] o_pc_a, o_imm_a;
  logic [4:0]  o_opcode_a, o_rd_a, o_rs1_a, o_rs2_a;
  logic [2:0]  o_format_a, o_funct3_a;
  logic [6:0]  o_funct7_a;

  logic        o_ready_b, o_valid_b, o_illegal_b;
  logic [31:0] o_pc_b;
  logic [63:0] o_imm_b;
  logic [4:0]  o_opcode_b, o_rd_b, o_rs1_b, o_rs2_b;
  logic [2:0]  o_format_b, o_funct3_b;
  logic [6:0]  o_funct7_b;

  core_decode_stage u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready_a),
    .i_instr(instr), .i_pc(pc), .o_valid(o_valid_a), .i_ready(rdy), .o_pc(o_pc_a),
    .o_opcode(o_opcode_a), .o_format(o_format_a), .o_imm(o_imm_a), .o_rd(o_rd_a),
    .o_rs1(o_rs1_a), .o_rs2(o_rs2_a), .o_funct3(o_funct3_a), .o_funct7(o_funct7_a),
    .o_illegal(o_illegal_a)
  );

  core_decode_stage #(.XLEN(64), .ENABLE_M(0), .ENABLE_A(1), .ENABLE_ZICSR(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready_b),
    .i_instr(instr), .i_pc(pc), .o_valid(o_valid_b), .i_ready(rdy), .o_pc(o_pc_b),
    .o_opcode(o_opcode_b), .o_format(o_format_b), .o_imm(o_imm_b), .o_rd(o_rd_b),
    .o_rs1(o_rs1_b), .o_rs2(o_rs2_b), .o_funct3(o_funct3_b), .o_funct7(o_funct7_b),
    .o_illegal(o_illegal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed { logic [31:0] pc; logic [31:0] w; } ent_t;
  typedef struct packed { logic [2:0] fmt; logic [63:0] imm; logic ill; } exp_t;
  ent_t mq[$];

  // Reference decode from the ISA field rules
  function automatic exp_t model(input logic [31:0] w, input bit x64, input bit m,
                                 input bit a, input bit z);
    exp_t e;
    longint s, imm;
    logic [4:0] op;
    bit known, ill;
    op = w[6:2];
    s  = longint'($signed(w));
    known = 1'b1;
    e.fmt = F_R;
    case (op)
      5'b01100, 5'b01110, 5'b01011:                   e.fmt = F_R;
      5'b00000, 5'b00100, 5'b00110, 5'b11001, 5'b00011: e.fmt = F_I;
      5'b01000:                                       e.fmt = F_S;
      5'b11000:                                       e.fmt = F_B;
      5'b01101, 5'b00101:                             e.fmt = F_U;
      5'b11011:                                       e.fmt = F_J;
      5'b11100:                                       e.fmt = w[14] ? F_UIMM : F_I;
      default:                                        known = 1'b0;
    endcase
    case (e.fmt)
      F_I:    imm = s >>> 20;
      F_S:    imm = (s >>> 25) * 32 + longint'(w[11:7]);
      F_B:    imm = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048 +
                    longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      F_U:    imm = (s >>> 12) * 4096;
      F_J:    imm = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096 +
                    longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      F_UIMM: imm = longint'(w[19:15]);
      default: imm = 0;
    endcase
    e.imm = imm;
    ill = (w[1:0] != 2'b11) || !known || (w == 32'h0) || (w == 32'hFFFFFFFF);
    if (op == 5'b01011 && !a) ill = 1'b1;
    if ((op == 5'b00110 || op == 5'b01110) && !x64) ill = 1'b1;
    if ((op == 5'b01100 || op == 5'b01110) &&
        !(w[31:25] == 7'd0 || w[31:25] == 7'h20 || (m && w[31:25] == 7'd1))) ill = 1'b1;
    if (op == 5'b11100 && w[14:12] != 3'd0 && !z) ill = 1'b1;
    e.ill = ill;
    return e;
  endfunction

  // Advance one clock, updating the occupancy model from the driven inputs
  task automatic step();
    bit acc, drn;
    acc = valid && (mq.size() < 2);
    drn = (mq.size() > 0) && rdy;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({pc, instr});
    end
    #1;
  endtask

  task automatic clear_stage();
    valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy = 1'b0; instr = '0; pc = '0;
    #3;
    n_checks++; if (o_valid_a !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid_a); else n_pass++;
    n_checks++; if (o_ready_a !== 1'b1) $display("FAIL reset_ready got %b exp 1", o_ready_a); else n_pass++;
    @(posedge clk); #1; rst = 1'b0; mq.delete();
    n_checks++; if (o_imm_b !== 64'h0 || o_pc_a !== 32'h0) $display("FAIL reset_data imm %h pc %h exp 0", o_imm_b, o_pc_a); else n_pass++;
    n_checks++; if (o_format_a !== F_R || o_illegal_a !== 1'b0) $display("FAIL reset_fmt fmt %0d ill %b exp 0/0", o_format_a, o_illegal_a); else n_pass++;
  endtask

  task automatic test_stream();
    clear_stage();
    rdy = 1'b1; valid = 1'b1; instr = 32'h00500093; pc = 32'h1000;
    step();
    instr = 32'hFE208EE3; pc = 32'h1004;
    n_checks++; if (o_valid_a !== 1'b1 || o_format_a !== F_I) $display("FAIL stream_addi_fmt v %b fmt %0d exp 1/%0d", o_valid_a, o_format_a, F_I); else n_pass++;
    n_checks++; if (o_imm_a !== 32'd5 || o_rd_a !== 5'd1) $display("FAIL stream_addi_imm imm %h rd %0d exp 5/1", o_imm_a, o_rd_a); else n_pass++;
    step();
    valid = 1'b0;
    n_checks++; if (o_valid_a !== 1'b1 || o_format_a !== F_B || o_pc_a !== 32'h1004) $display("FAIL stream_beq_fmt v %b fmt %0d pc %h exp 1/%0d/1004", o_valid_a, o_format_a, o_pc_a, F_B); else n_pass++;
    n_checks++; if (o_imm_a !== 32'hFFFFFFFC || o_imm_b !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL stream_beq_imm a %h b %h exp -4", o_imm_a, o_imm_b); else n_pass++;
    n_checks++; if (o_ready_a !== 1'b1) $display("FAIL stream_ready got %b exp 1", o_ready_a); else n_pass++;
    step();
    n_checks++; if (o_valid_a !== 1'b0) $display("FAIL stream_drained got %b exp 0", o_valid_a); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_stage();
    rdy = 1'b0; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = 32'h00000013 | (32'(i + 1) << 20); pc = 32'h2000 + 32'(4 * i);
      if (i == 3) begin instr = 32'h00300113; pc = 32'h2008; end
      if (i >= 2) begin instr = 32'h00300113; pc = 32'h2008; end
      step();
      n_checks++; if (o_ready_a !== (i == 0)) $display("FAIL bp_ready cyc %0d got %b exp %b", i, o_ready_a, i == 0); else n_pass++;
      n_checks++; if (o_valid_a !== 1'b1 || o_pc_a !== 32'h2000) $display("FAIL bp_hold cyc %0d v %b pc %h exp 1/2000", i, o_valid_a, o_pc_a); else n_pass++;
    end
    rdy = 1'b1;
    step();
    n_checks++; if (o_pc_a !== 32'h2004 || o_imm_a !== 32'd2) $display("FAIL bp_second pc %h imm %h exp 2004/2", o_pc_a, o_imm_a); else n_pass++;
    n_checks++; if (o_ready_a !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", o_ready_a); else n_pass++;
    step();
    valid = 1'b0;
    n_checks++; if (o_pc_a !== 32'h2008 || o_imm_a !== 32'd3 || o_rd_a !== 5'd2) $display("FAIL bp_third pc %h imm %h rd %0d exp 2008/3/2", o_pc_a, o_imm_a, o_rd_a); else n_pass++;
    step();
    n_checks++; if (o_valid_a !== 1'b0) $display("FAIL bp_no_dup got %b exp 0", o_valid_a); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] words [6] = '{32'h0, 32'h02208033, 32'h0000102F, 32'h3001D073, 32'h0050009B, 32'hFFFFFFFF};
    bit ill_a [6] = '{1, 0, 1, 0, 1, 1};
    bit ill_b [6] = '{1, 1, 0, 1, 0, 1};
    clear_stage();
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; instr = words[i]; pc = 32'h3000 + 32'(i);
      step();
      valid = 1'b0;
      n_checks++; if (o_valid_a !== 1'b1 || o_illegal_a !== ill_a[i]) $display("FAIL illegal_a %h v %b ill %b exp 1/%b", words[i], o_valid_a, o_illegal_a, ill_a[i]); else n_pass++;
      n_checks++; if (o_illegal_b !== ill_b[i]) $display("FAIL illegal_b %h ill %b exp %b", words[i], o_illegal_b, ill_b[i]); else n_pass++;
      if (i == 3) begin
        n_checks++; if (o_format_a !== F_UIMM || o_imm_a !== 32'd3 || o_imm_b !== 64'd3) $display("FAIL csr_uimm fmt %0d imm %h/%h exp %0d/3", o_format_a, o_imm_a, o_imm_b, F_UIMM); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_flush();
    clear_stage();
    rdy = 1'b0; valid = 1'b1;
    instr = 32'h00100093; pc = 32'h4000; step();
    instr = 32'h00200093; pc = 32'h4004; step();
    instr = 32'h00300093; pc = 32'h4008; flush = 1'b1; step(); flush = 1'b0;
    n_checks++; if (o_valid_a !== 1'b0 || o_ready_a !== 1'b1) $display("FAIL flush_full v %b r %b exp 0/1", o_valid_a, o_ready_a); else n_pass++;
    instr = 32'h00400093; pc = 32'h400C; step();
    n_checks++; if (o_valid_a !== 1'b1 || o_pc_a !== 32'h400C) $display("FAIL flush_after v %b pc %h exp 1/400c", o_valid_a, o_pc_a); else n_pass++;
    // Flush while ready is high: the presented entry must be dropped
    instr = 32'h00500093; pc = 32'h4010; flush = 1'b1; step(); flush = 1'b0; valid = 1'b0;
    n_checks++; if (o_valid_a !== 1'b0 || o_ready_a !== 1'b1) $display("FAIL flush_drop v %b r %b exp 0/1", o_valid_a, o_ready_a); else n_pass++;
    step();
    n_checks++; if (o_valid_a !== 1'b0) $display("FAIL flush_ghost v %b pc %h exp 0", o_valid_a, o_pc_a); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    clear_stage();
    rdy = 1'b0; valid = 1'b1;
    instr = 32'h00700093; pc = 32'h5000; step();
    instr = 32'h00800093; pc = 32'h5004; step();
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o_valid_a !== 1'b0 || o_valid_b !== 1'b0) $display("FAIL rstmid_valid a %b b %b exp 0", o_valid_a, o_valid_b); else n_pass++;
    mq.delete();
    @(posedge clk); #1 rst = 1'b0;
    n_checks++; if (o_ready_a !== 1'b1 || o_imm_a !== 32'h0 || o_pc_a !== 32'h0 || o_rd_a !== 5'd0 || o_format_a !== F_R) $display("FAIL rstmid_data r %b imm %h pc %h rd %0d fmt %0d exp 1/0/0/0/0", o_ready_a, o_imm_a, o_pc_a, o_rd_a, o_format_a); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] ops [14] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b01011,
                             5'b01100, 5'b01101, 5'b01110, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
    exp_t ea, eb;
    bit ev;
    int k;
    clear_stage();
    for (int c = 0; c < 600; c++) begin
      ev = (mq.size() > 0);
      n_checks++; if (o_valid_a !== ev || o_valid_b !== ev) $display("FAIL rnd_valid cyc %0d a %b b %b exp %b", c, o_valid_a, o_valid_b, ev); else n_pass++;
      n_checks++; if (o_ready_a !== (mq.size() < 2) || o_ready_b !== (mq.size() < 2)) $display("FAIL rnd_ready cyc %0d a %b b %b exp %b", c, o_ready_a, o_ready_b, mq.size() < 2); else n_pass++;
      if (ev) begin
        ea = model(mq[0].w, 1'b0, 1'b1, 1'b0, 1'b1);
        eb = model(mq[0].w, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (o_pc_a !== mq[0].pc || o_pc_b !== mq[0].pc) $display("FAIL rnd_pc cyc %0d got %h exp %h", c, o_pc_a, mq[0].pc); else n_pass++;
        n_checks++; if (o_opcode_a !== mq[0].w[6:2] || o_funct3_a !== mq[0].w[14:12] || o_funct7_a !== mq[0].w[31:25]) $display("FAIL rnd_fields cyc %0d w %h op %h f3 %h f7 %h", c, mq[0].w, o_opcode_a, o_funct3_a, o_funct7_a); else n_pass++;
        n_checks++; if (o_rd_a !== mq[0].w[11:7] || o_rs1_a !== mq[0].w[19:15] || o_rs2_a !== mq[0].w[24:20]) $display("FAIL rnd_regs cyc %0d w %h rd %0d rs1 %0d rs2 %0d", c, mq[0].w, o_rd_a, o_rs1_a, o_rs2_a); else n_pass++;
        n_checks++; if (o_format_a !== ea.fmt || o_format_b !== eb.fmt) $display("FAIL rnd_fmt cyc %0d w %h a %0d b %0d exp %0d/%0d", c, mq[0].w, o_format_a, o_format_b, ea.fmt, eb.fmt); else n_pass++;
        n_checks++; if (o_imm_a !== ea.imm[31:0]) $display("FAIL rnd_imm_a cyc %0d w %h got %h exp %h", c, mq[0].w, o_imm_a, ea.imm[31:0]); else n_pass++;
        n_checks++; if (o_imm_b !== eb.imm) $display("FAIL rnd_imm_b cyc %0d w %h got %h exp %h", c, mq[0].w, o_imm_b, eb.imm); else n_pass++;
        n_checks++; if (o_illegal_a !== ea.ill || o_illegal_b !== eb.ill) $display("FAIL rnd_ill cyc %0d w %h a %b b %b exp %b/%b", c, mq[0].w, o_illegal_a, o_illegal_b, ea.ill, eb.ill); else n_pass++;
      end
      valid = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      pc    = $urandom;
      instr = $urandom;
      k = $urandom_range(0, 15);
      if (k < 14) instr[6:2] = ops[k];
      if ($urandom_range(0, 7) != 0) instr[1:0] = 2'b11;
      if ($urandom_range(0, 1) != 0) instr[31:25] = f7s[$urandom_range(0, 2)];
      if ($urandom_range(0, 49) == 0) instr = 32'h0;
      if ($urandom_range(0, 49) == 0) instr = 32'hFFFFFFFF;
      step();
      flush = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_decode_stage.md
Name: core_decode_stage

Overview:
- Registered RV32 instruction decode stage, parametrised successor to the core's shared opcode/format/register-index type definitions.
- Accepts fetched instruction words over a valid/ready handshake.
- Outputs an opcode, instruction format, sign-extended immediate, register indices and an illegal-instruction flag.
- Sits between fetch and execute. Carries a 2-entry skid buffer so backpressure never combinationally reaches fetch. Supports pipeline flush.

Parameters:
- XLEN, 32, immediate output width (32 or 64); immediates sign-extend to XLEN, UIMM zero-extends.
- ENABLE_M, 1, OP/OP_32 with funct7=7'b0000001 is legal only when 1.
- ENABLE_A, 0, opcode AMO is legal only when 1.
- ENABLE_ZICSR, 1, SYSTEM funct3!=0 (CSR ops) is legal only when 1.
- PC_WIDTH, 32, width of the PC carried alongside the instruction.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_flush  in  1  discard all buffered entries this cycle
- i_valid  in  1  fetch presents an instruction
- o_ready  out  1  stage can accept (registered)
- i_instr  in  32  instruction word
- i_pc  in  PC_WIDTH  instruction address
- o_valid  out  1  decoded entry available
- i_ready  in  1  execute accepts entry
- o_pc  out  PC_WIDTH  PC of the decoded entry
- o_opcode  out  5  instr[6:2], opcode enum
- o_format  out  3  instruction format enum (R,I,S,B,U,J,UIMM)
- o_imm  out  XLEN  decoded immediate
- o_rd, o_rs1, o_rs2  out  5 each  register indices (reg_index_t)
- o_funct3  out  3  instr[14:12]
- o_funct7  out  7  instr[31:25]
- o_illegal  out  1  entry is an illegal instruction

Behaviour:
- Reset, asynchronous, active-high, takes effect immediately:
  - o_valid=0, skid valid=0, o_ready=1.
  - All data outputs are 0; o_format resets to R.
- Handshakes:
  - Input transfer = i_valid&o_ready. Output transfer = o_valid&i_ready.
  - Decode is combinational on i_instr at input transfer; the result is registered. Latency is exactly 1 cycle from input transfer to o_valid when the output register is empty or draining.
- Storage is an output register (OR) plus a skid register (SK):
  - Input transfer while OR is empty or draining: decoded entry loads OR.
  - Input transfer while OR is full and not draining: entry loads SK and o_ready falls next cycle.
  - Output transfer while SK is full: SK moves into OR, SK is cleared and o_ready rises next cycle.
- o_ready = ~SK_valid, registered. No combinational path from i_ready to o_ready.
- Once o_valid=1, all data outputs hold stable until output transfer.
- i_flush has priority over every transfer:
  - Next cycle o_valid=0, SK empty, o_ready=1.
  - An input presented during the flush cycle is dropped.
- Format mapping by opcode:
  - OP, OP_32, AMO → R.
  - LOAD, OP_IMM, OP_IMM_32, JALR, MISC_MEM → I.
  - STORE → S. BRANCH → B. LUI, AUIPC → U. JAL → J.
  - SYSTEM with funct3[2]=1 → UIMM; other SYSTEM → I.
  - Anything else → R, with illegal set.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U = sext({instr[31:12], 12'b0}).
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - UIMM = zext(instr[19:15]).
  - R → 0.
- Illegal when any of the following holds:
  - instr[1:0]!=2'b11.
  - Opcode is outside {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM}, plus AMO when ENABLE_A=1.
  - OP_IMM_32 or OP_32 while XLEN=32.
  - OP funct7 not in {0000000, 0100000}; funct7=0000001 is also accepted when ENABLE_M=1.
  - SYSTEM funct3!=0 while ENABLE_ZICSR=0.
  - instr == 32'h0 or 32'hFFFFFFFF.
- Illegal entries still flow through the handshake with o_illegal=1; other fields decode per the rules above.
- Simultaneous output drain and input while SK is empty: OR is replaced in the same edge, giving continuous throughput of 1/cycle.

Test Plan:
- Reset mid-stream: assert i_rst with OR and SK both full → same cycle o_valid=0; after release o_ready=1 and outputs are 0.
- Streaming with i_ready=1: i_instr=32'h00500093 (addi x1,x0,5), then 32'hFE208EE3 (beq) → o_format=I, o_imm=5, o_rd=1; next cycle o_format=B, o_imm=-4 (32'hFFFFFFFC). Throughput 1/cycle.
- Backpressure: i_ready=0 while 3 instructions are offered back-to-back → first two accepted, o_ready=0 from cycle 3. Release i_ready → entries emerge in order, o_ready returns to 1, no loss or duplication.
- Illegal detection: 32'h0, 32'h02208033 (mul) with ENABLE_M=0, and 32'h0000102F (AMO) with ENABLE_A=0 → o_illegal=1 for each. With ENABLE_M=1, mul gives o_illegal=0.
- Flush: OR and SK full, i_flush=1 with i_valid=1 → next cycle o_valid=0, o_ready=1, the flushed-cycle input never appears.
- CSR UIMM: 32'h3001D073 (csrrwi mstatus,3) → o_format=UIMM, o_imm=3, o_illegal=0. With ENABLE_ZICSR=0 → o_illegal=1.
